// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one m_spi register-access master between
// NREQ requesters; one event pulse per accepted request, response with timeout.
module spi_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int AWIDTH      = 15,
    parameter int DWIDTH      = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 8
) (
    input  logic                     user_clk,
    input  logic                     user_rst,
    input  logic [NREQ-1:0]          i_req_vld,
    output logic [NREQ-1:0]          o_req_rdy,
    input  logic [NREQ-1:0]          i_req_rw,
    input  logic [NREQ*AWIDTH-1:0]   i_req_addr,
    input  logic [NREQ*DWIDTH-1:0]   i_req_wdata,
    output logic [NREQ-1:0]          o_rsp_vld,
    output logic [DWIDTH-1:0]        o_rsp_data,
    output logic                     o_rsp_err,
    output logic                     o_busy,
    output logic                     o_spi_rd_evt,
    output logic                     o_spi_wr_evt,
    output logic [AWIDTH-1:0]        o_spi_addr,
    output logic [DWIDTH-1:0]        o_spi_wr_data,
    input  logic                     i_spi_rd_evt,
    input  logic [DWIDTH-1:0]        i_spi_rd_data,
    input  logic                     i_spi_done_evt
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    owner;
    logic                cap_rw;
    logic [TO_W-1:0]     to_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                rd_seen;
    logic                done_seen;
    logic [DWIDTH-1:0]   rd_data_q;

    logic [PTR_W-1:0]    grant;
    logic                grant_vld;
    logic [PTR_W:0]      scan_idx;
    logic                sel_rw;
    logic [AWIDTH-1:0]   sel_addr;
    logic [DWIDTH-1:0]   sel_wdata;
    logic                rd_any;
    logic                done_any;
    logic                complete;

    // Scan from the pointer upward; iterating downward lets the nearest requester win.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_idx = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (scan_idx >= (PTR_W + 1)'(NREQ)) begin
                scan_idx = scan_idx - (PTR_W + 1)'(NREQ);
            end
            if (i_req_vld[scan_idx[PTR_W-1:0]]) begin
                grant     = scan_idx[PTR_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    // Payload of the granted requester.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == PTR_W'(k)) begin
                sel_rw    = i_req_rw[k];
                sel_addr  = i_req_addr[k*AWIDTH +: AWIDTH];
                sel_wdata = i_req_wdata[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign o_req_rdy = (state == ST_IDLE && grant_vld && !user_rst)
                       ? (NREQ'(1) << grant) : '0;

    // Completion includes events arriving this cycle, so no extra latency.
    assign rd_any   = rd_seen | i_spi_rd_evt;
    assign done_any = done_seen | i_spi_done_evt;
    assign complete = cap_rw ? done_any : (rd_any & done_any);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            owner         <= '0;
            cap_rw        <= 1'b0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            rd_seen       <= 1'b0;
            done_seen     <= 1'b0;
            rd_data_q     <= '0;
            o_rsp_vld     <= '0;
            o_rsp_data    <= '0;
            o_rsp_err     <= 1'b0;
            o_busy        <= 1'b0;
            o_spi_rd_evt  <= 1'b0;
            o_spi_wr_evt  <= 1'b0;
            o_spi_addr    <= '0;
            o_spi_wr_data <= '0;
        end else begin
            o_spi_rd_evt <= 1'b0;
            o_spi_wr_evt <= 1'b0;
            o_rsp_vld    <= '0;
            o_rsp_data   <= '0;
            o_rsp_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        owner         <= grant;
                        cap_rw        <= sel_rw;
                        o_spi_addr    <= sel_addr;
                        o_spi_wr_data <= sel_wdata;
                        ptr           <= (grant == PTR_W'(NREQ - 1)) ? '0 : grant + 1'b1;
                        o_spi_wr_evt  <= sel_rw;
                        o_spi_rd_evt  <= !sel_rw;
                        o_busy        <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt    <= '0;
                    rd_seen   <= 1'b0;
                    done_seen <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_spi_rd_evt) begin
                        rd_seen   <= 1'b1;
                        rd_data_q <= i_spi_rd_data;
                    end
                    if (i_spi_done_evt) begin
                        done_seen <= 1'b1;
                    end
                    if (complete) begin
                        o_rsp_vld  <= NREQ'(1) << owner;
                        o_rsp_data <= cap_rw ? '0 : (i_spi_rd_evt ? i_spi_rd_data : rd_data_q);
                        state      <= ST_RESP;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        o_rsp_vld <= NREQ'(1) << owner;
                        o_rsp_err <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    gap_cnt <= '0;
                    if (GAP_CYC == 0) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter with a behavioural m_spi stub
// whose event latencies and read data are configurable per scenario.
module tb_spi_req_arbiter;

    localparam int NREQ        = 4;
    localparam int AWIDTH      = 15;
    localparam int DWIDTH      = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int GAP_CYC     = 2;

    logic                   user_clk = 1'b0;
    logic                   user_rst;
    logic [NREQ-1:0]        i_req_vld;
    logic [NREQ-1:0]        o_req_rdy;
    logic [NREQ-1:0]        i_req_rw;
    logic [NREQ*AWIDTH-1:0] i_req_addr;
    logic [NREQ*DWIDTH-1:0] i_req_wdata;
    logic [NREQ-1:0]        o_rsp_vld;
    logic [DWIDTH-1:0]      o_rsp_data;
    logic                   o_rsp_err;
    logic                   o_busy;
    logic                   o_spi_rd_evt;
    logic                   o_spi_wr_evt;
    logic [AWIDTH-1:0]      o_spi_addr;
    logic [DWIDTH-1:0]      o_spi_wr_data;
    logic                   i_spi_rd_evt   = 1'b0;
    logic [DWIDTH-1:0]      i_spi_rd_data  = '0;
    logic                   i_spi_done_evt = 1'b0;

    spi_req_arbiter #(
        .NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
        .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .user_clk(user_clk), .user_rst(user_rst),
        .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_rw(i_req_rw),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_vld(o_rsp_vld), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_busy(o_busy), .o_spi_rd_evt(o_spi_rd_evt), .o_spi_wr_evt(o_spi_wr_evt),
        .o_spi_addr(o_spi_addr), .o_spi_wr_data(o_spi_wr_data),
        .i_spi_rd_evt(i_spi_rd_evt), .i_spi_rd_data(i_spi_rd_data),
        .i_spi_done_evt(i_spi_done_evt)
    );

    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int               owner;
        logic [DWIDTH-1:0] data;
        logic             err;
    } rsp_exp_t;

    typedef struct {
        logic              rw;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] wdata;
    } evt_exp_t;

    rsp_exp_t rsp_q[$];
    evt_exp_t evt_q[$];
    int       grant_log[$];

    // Scenario knobs shared by the stub and the scoreboard.
    int rd_lat = 4;
    int done_lat = 5;
    bit force_3c = 1'b0;
    bit expect_timeout = 1'b0;

    bit [DWIDTH-1:0] ref_mem [256];
    bit [DWIDTH-1:0] stub_mem [256];

    int cyc = 0, n_acc = 0, n_evt = 0, n_rsp = 0;
    int done_cyc = 0, rsp_cyc = 0, issue_cyc = 0;
    logic [NREQ-1:0] last_acc = '0;

    // m_spi stub: fires rd/done events a configurable number of cycles after the request pulse.
    int rd_cd = 0, done_cd = 0;
    always @(posedge user_clk) begin
        i_spi_rd_evt   <= 1'b0;
        i_spi_done_evt <= 1'b0;
        if (user_rst) begin
            rd_cd   = 0;
            done_cd = 0;
        end else begin
            if (rd_cd == 1) begin
                i_spi_rd_evt  <= 1'b1;
                i_spi_rd_data <= force_3c ? 8'h3C : stub_mem[o_spi_addr[7:0]];
            end
            if (done_cd == 1) i_spi_done_evt <= 1'b1;
            if (rd_cd > 0) rd_cd--;
            if (done_cd > 0) done_cd--;
            if (o_spi_wr_evt) begin
                stub_mem[o_spi_addr[7:0]] = o_spi_wr_data;
                done_cd = done_lat;
            end
            if (o_spi_rd_evt) begin
                rd_cd   = rd_lat;
                done_cd = done_lat;
            end
        end
    end

    // Monitor and scoreboard.
    always @(posedge user_clk) begin
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] oh;
        int              k;
        rsp_exp_t        e;
        evt_exp_t        ev;
        cyc++;
        if (user_rst) begin
            rsp_q.delete();
            evt_q.delete();
            last_acc = '0;
        end else begin
            acc      = i_req_vld & o_req_rdy;
            last_acc = acc;
            if (o_req_rdy != '0) check("rdy_onehot", 32'($onehot(o_req_rdy)), 1);
            if (acc != '0) begin
                k = 0;
                for (int i = 0; i < NREQ; i++) if (acc[i]) k = i;
                grant_log.push_back(k);
                n_acc++;
                ev.rw    = i_req_rw[k];
                ev.addr  = i_req_addr[k*AWIDTH +: AWIDTH];
                ev.wdata = i_req_wdata[k*DWIDTH +: DWIDTH];
                evt_q.push_back(ev);
                e.owner = k;
                e.err   = expect_timeout;
                e.data  = '0;
                if (!expect_timeout) begin
                    if (ev.rw) ref_mem[ev.addr[7:0]] = ev.wdata;
                    else e.data = force_3c ? 8'h3C : ref_mem[ev.addr[7:0]];
                end
                rsp_q.push_back(e);
            end
            if (o_spi_rd_evt || o_spi_wr_evt) begin
                n_evt++;
                issue_cyc = cyc;
                check("evt_excl", 32'(o_spi_rd_evt & o_spi_wr_evt), 0);
                if (evt_q.size() == 0) begin
                    check("evt_unexpected", 1, 0);
                end else begin
                    ev = evt_q.pop_front();
                    check("evt_rw", 32'(o_spi_wr_evt), 32'(ev.rw));
                    check("evt_addr", 32'(o_spi_addr), 32'(ev.addr));
                    if (ev.rw) check("evt_wdata", 32'(o_spi_wr_data), 32'(ev.wdata));
                end
            end
            if (i_spi_done_evt) done_cyc = cyc;
            if (o_rsp_vld != '0) begin
                rsp_cyc = cyc;
                n_rsp++;
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e  = rsp_q.pop_front();
                    oh = '0;
                    oh[e.owner] = 1'b1;
                    check("rsp_owner", 32'(o_rsp_vld), 32'(oh));
                    check("rsp_data", 32'(o_rsp_data), 32'(e.data));
                    check("rsp_err", 32'(o_rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Advance one cycle, dropping any request accepted on the last edge.
    task automatic step();
        @(negedge user_clk);
        i_req_vld = i_req_vld & ~last_acc;
    endtask

    task automatic set_req(input int k, input logic rw, input logic [AWIDTH-1:0] addr,
                           input logic [DWIDTH-1:0] wd);
        i_req_rw[k]                     = rw;
        i_req_addr[k*AWIDTH +: AWIDTH]  = addr;
        i_req_wdata[k*DWIDTH +: DWIDTH] = wd;
        i_req_vld[k]                    = 1'b1;
    endtask

    task automatic wait_rsp(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && n_rsp < target; i++) step();
        check(tag, n_rsp, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_rsp_vld"}, 32'(o_rsp_vld), 0);
        check({tag, "_rsp_data"}, 32'(o_rsp_data), 0);
        check({tag, "_rsp_err"}, 32'(o_rsp_err), 0);
        check({tag, "_evts"}, 32'({o_spi_rd_evt, o_spi_wr_evt}), 0);
        check({tag, "_addr"}, 32'(o_spi_addr), 0);
        check({tag, "_wdata"}, 32'(o_spi_wr_data), 0);
    endtask

    initial begin
        int base;
        user_rst    = 1'b1;
        i_req_vld   = '0;
        i_req_rw    = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        repeat (3) @(negedge user_clk);
        check_outputs_zero("reset");
        check("reset_rdy", 32'(o_req_rdy), 0);
        user_rst = 1'b0;

        // Single write, read-back, then one more to bring the pointer to 0.
        set_req(1, 1'b1, 15'h0012, 8'hA5);
        wait_rsp("wr_complete", 1, 100);
        check("wr_rsp_after_done", 32'(rsp_cyc - done_cyc), 1);
        set_req(2, 1'b0, 15'h0012, 8'h00);
        wait_rsp("rd_complete", 2, 100);
        set_req(3, 1'b1, 15'h0030, 8'h5A);
        wait_rsp("wr3_complete", 3, 100);

        // Contention: all four valid, two rounds.
        base = grant_log.size();
        for (int k = 0; k < NREQ; k++)
            if (k % 2 == 0) set_req(k, 1'b1, 15'(16'h20 + k), 8'(8'h11 * (k + 1)));
            else set_req(k, 1'b0, 15'h0012, 8'h00);
        wait_rsp("cont_round1", 7, 200);
        for (int k = 0; k < NREQ; k++)
            if (k % 2 == 0) set_req(k, 1'b0, 15'(16'h20 + k), 8'h00);
            else set_req(k, 1'b1, 15'h0030, 8'(8'h40 + k));
        wait_rsp("cont_round2", 11, 200);
        for (int i = 0; i < 2 * NREQ; i++)
            check($sformatf("grant_order_%0d", i),
                  (base + i < grant_log.size()) ? grant_log[base + i] : -1, i % NREQ);
        repeat (GAP_CYC + 2) step();
        check("busy_idle", 32'(o_busy), 0);

        // Event ordering: done 5 cycles before rd, then both in the same cycle.
        force_3c = 1'b1;
        rd_lat = 8; done_lat = 3;
        set_req(0, 1'b0, 15'h0040, 8'h00);
        wait_rsp("done_first", 12, 100);
        check("done_first_rsp_after_rd", 32'(rsp_cyc - done_cyc), 6);
        rd_lat = 4; done_lat = 4;
        set_req(3, 1'b0, 15'h0041, 8'h00);
        wait_rsp("same_cycle", 13, 100);
        check("same_cycle_lat", 32'(rsp_cyc - done_cyc), 1);
        force_3c = 1'b0;

        // Timeout with a late done afterwards.
        expect_timeout = 1'b1;
        rd_lat = 0; done_lat = 80;
        set_req(1, 1'b0, 15'h0012, 8'h00);
        wait_rsp("timeout_rsp", 14, 200);
        check("timeout_delay", 32'(rsp_cyc - issue_cyc), TIMEOUT_CYC + 1);
        expect_timeout = 1'b0;
        repeat (40) step();
        check("late_done_seen", 32'(done_cyc > rsp_cyc), 1);
        check("late_done_ignored", n_rsp, 14);
        check("late_done_busy", 32'(o_busy), 0);

        // Reset in the middle of WAIT, then normal traffic.
        rd_lat = 20; done_lat = 20;
        base = n_evt;
        set_req(2, 1'b0, 15'h0012, 8'h00);
        for (int i = 0; i < 20 && n_evt == base; i++) step();
        check("rst_issue_seen", n_evt, base + 1);
        repeat (3) step();
        check("rst_busy_before", 32'(o_busy), 1);
        user_rst = 1'b1;
        step();
        user_rst = 1'b0;
        check_outputs_zero("midrst");
        repeat (30) step();
        check("midrst_no_rsp", n_rsp, 14);
        rd_lat = 4; done_lat = 5;
        base = grant_log.size();
        for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 15'(16'h50 + k), 8'(8'hC0 + k));
        wait_rsp("post_rst", 18, 200);
        check("post_rst_first_grant", (base < grant_log.size()) ? grant_log[base] : -1, 0);
        repeat (GAP_CYC + 2) step();
        check("final_rsp_q_empty", rsp_q.size(), 0);
        check("final_evt_per_acc", n_evt, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
